// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: slave end of the 68000 asynchronous bus for one
// address window. It converts AS/UDS/LDS/RW cycles into single-cycle
// requests to a synchronous backend with a ready/ack handshake, then
// asserts nDTACK after WAIT_CYCLES and releases it when nAS negates.
//
// Ports:
//   clk, nRESET          clock (shared with fx68k), async active-low reset
//   M68K_ADDR/WDATA/RW   CPU word address [23:1], write data, 1=read
//   nAS, nUDS, nLDS      CPU strobes, active-low
//   nDTACK, RDATA        data acknowledge (active-low), read data
//   DATA_OE              RDATA valid for a read in this window
//   BK_ADDR/WDATA/BE     latched backend request fields
//   BK_RD, BK_WR         one-cycle request pulses
//   BK_RDATA, BK_ACK     backend read data and completion pulse
//   TIMEOUT_FLAG         sticky backend-timeout indicator
//
// Optional feature: define M68K_BUS_RESPONDER_TIMEOUT_EN to enable the
// REQ watchdog (TIMEOUT cycles). Without it TIMEOUT_FLAG is tied to 0.

module m68k_bus_responder #(
    parameter logic [23:0] BASE        = 24'h100000,
    parameter logic [23:0] MASK        = 24'hFF0000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [22:0] M68K_ADDR,
    input  logic [15:0] M68K_WDATA,
    input  logic        M68K_RW,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    output logic        nDTACK,
    output logic [15:0] RDATA,
    output logic        DATA_OE,
    output logic [22:0] BK_ADDR,
    output logic [15:0] BK_WDATA,
    output logic [1:0]  BK_BE,
    output logic        BK_RD,
    output logic        BK_WR,
    input  logic [15:0] BK_RDATA,
    input  logic        BK_ACK,
    output logic        TIMEOUT_FLAG
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_ABORT
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [22:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [1:0]  be_q;
    logic        rw_q;
    logic        rd_q;
    logic        wr_q;
    logic [3:0]  wcnt;

    logic        hit;
    logic        start;
    logic        ack_v;
    logic        timeout_hit;

    assign hit   = ({M68K_ADDR, 1'b0} & MASK) == (BASE & MASK);
    // For writes the 68k drives the data strobes late, so the cycle only
    // starts once at least one strobe is low.
    assign start = (state == S_IDLE) && !nAS && (!nUDS || !nLDS) && hit;
    // The backend cannot answer in the cycle of its own request pulse.
    assign ack_v = BK_ACK && !(rd_q || wr_q);

`ifdef M68K_BUS_RESPONDER_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_flag;

    // ABORT also honours the watchdog so a dead backend cannot wedge
    // the responder after the CPU gave up on a cycle.
    assign timeout_hit = ((state == S_REQ) || (state == S_ABORT)) &&
                         !ack_v && (to_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (start)
                to_cnt <= '0;
            else if ((state == S_REQ) || (state == S_ABORT))
                to_cnt <= to_cnt + 16'd1;
            if ((state == S_REQ) && timeout_hit)
                to_flag <= 1'b1;
        end
    end

    assign TIMEOUT_FLAG = to_flag;
`else
    assign timeout_hit  = 1'b0;
    assign TIMEOUT_FLAG = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_n = S_REQ;
            end
            S_REQ: begin
                if (ack_v)
                    state_n = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                else if (timeout_hit)
                    state_n = S_ACK;
                else if (nAS)
                    state_n = S_ABORT;
            end
            S_WAIT: begin
                if (nAS)
                    state_n = S_IDLE;
                else if (wcnt == 4'd1)
                    state_n = S_ACK;
            end
            S_ACK: begin
                if (nAS)
                    state_n = S_IDLE;
            end
            S_ABORT: begin
                if (ack_v || timeout_hit)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            rw_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wcnt    <= '0;
        end else begin
            rd_q <= start && M68K_RW;
            wr_q <= start && !M68K_RW;
            if (start) begin
                addr_q  <= M68K_ADDR;
                wdata_q <= M68K_WDATA;
                be_q    <= {~nUDS, ~nLDS};
                rw_q    <= M68K_RW;
            end
            if ((state == S_REQ) && ack_v) begin
                if (rw_q)
                    rdata_q <= BK_RDATA;
                wcnt <= 4'(WAIT_CYCLES);
            end else if ((state == S_REQ) && timeout_hit) begin
                if (rw_q)
                    rdata_q <= 16'hFFFF;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // nDTACK and DATA_OE decode the state register directly, so they
    // change on the entry edge and clear asynchronously on reset.
    always_comb begin
        nDTACK   = (state != S_ACK);
        DATA_OE  = (state == S_ACK) && rw_q;
        RDATA    = rdata_q;
        BK_ADDR  = addr_q;
        BK_WDATA = wdata_q;
        BK_BE    = be_q;
        BK_RD    = rd_q;
        BK_WR    = wr_q;
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: directed bench for m68k_bus_responder.
// Scenario tasks drive the CPU/backend pins and compare inline.

module tb_m68k_bus_responder;

    logic        clk = 1'b0;
    logic        nRESET;
    logic [22:0] M68K_ADDR;
    logic [15:0] M68K_WDATA;
    logic        M68K_RW;
    logic        nAS, nUDS, nLDS;
    logic        nDTACK;
    logic [15:0] RDATA;
    logic        DATA_OE;
    logic [22:0] BK_ADDR;
    logic [15:0] BK_WDATA;
    logic [1:0]  BK_BE;
    logic        BK_RD, BK_WR;
    logic [15:0] BK_RDATA;
    logic        BK_ACK;
    logic        TIMEOUT_FLAG;

    int tests = 0;
    int fails = 0;
    logic [15:0] last_rd = 16'h0000;

    always #5 clk = ~clk;

    m68k_bus_responder #(
        .BASE(24'h100000),
        .MASK(24'hFF0000),
        .WAIT_CYCLES(2),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .nRESET(nRESET),
        .M68K_ADDR(M68K_ADDR),
        .M68K_WDATA(M68K_WDATA),
        .M68K_RW(M68K_RW),
        .nAS(nAS),
        .nUDS(nUDS),
        .nLDS(nLDS),
        .nDTACK(nDTACK),
        .RDATA(RDATA),
        .DATA_OE(DATA_OE),
        .BK_ADDR(BK_ADDR),
        .BK_WDATA(BK_WDATA),
        .BK_BE(BK_BE),
        .BK_RD(BK_RD),
        .BK_WR(BK_WR),
        .BK_RDATA(BK_RDATA),
        .BK_ACK(BK_ACK),
        .TIMEOUT_FLAG(TIMEOUT_FLAG)
    );

    task automatic bus_idle();
        nAS     = 1'b1;
        nUDS    = 1'b1;
        nLDS    = 1'b1;
        M68K_RW = 1'b1;
    endtask

    // Full word read with an ack one cycle after BK_RD.
    task automatic do_read(input logic [23:0] baddr,
                           input logic [15:0] d,
                           input string tag);
        logic [22:0] wa;
        wa = baddr[23:1];
        @(negedge clk);
        M68K_ADDR = wa;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b0;
        BK_RDATA  = d;
        @(negedge clk);
        tests++;
        if (BK_RD !== 1'b1 || BK_WR !== 1'b0) begin
            fails++;
            $display("FAIL %s rd_pulse: rd=%b wr=%b want rd=1 wr=0",
                     tag, BK_RD, BK_WR);
        end
        tests++;
        if (BK_ADDR !== wa || BK_BE !== 2'b11) begin
            fails++;
            $display("FAIL %s req: addr=%h be=%b want addr=%h be=11",
                     tag, BK_ADDR, BK_BE, wa);
        end
        @(negedge clk);
        tests++;
        if (BK_RD !== 1'b0 || nDTACK !== 1'b1) begin
            fails++;
            $display("FAIL %s pulse_end: rd=%b dtack=%b want 0 1",
                     tag, BK_RD, nDTACK);
        end
        BK_ACK = 1'b1;
        @(negedge clk);
        BK_ACK = 1'b0;
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b1) begin
            fails++;
            $display("FAIL %s early_dtack: got %b want 1", tag, nDTACK);
        end
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b0 || DATA_OE !== 1'b1 || RDATA !== d) begin
            fails++;
            $display("FAIL %s ack: dtack=%b oe=%b rdata=%h want 0 1 %h",
                     tag, nDTACK, DATA_OE, RDATA, d);
        end
        bus_idle();
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b1 || DATA_OE !== 1'b0 || RDATA !== d) begin
            fails++;
            $display("FAIL %s release: dtack=%b oe=%b rdata=%h want 1 0 %h",
                     tag, nDTACK, DATA_OE, RDATA, d);
        end
        last_rd = d;
    endtask

    task automatic test_reset();
        nRESET     = 1'b0;
        bus_idle();
        M68K_ADDR  = '0;
        M68K_WDATA = '0;
        BK_RDATA   = '0;
        BK_ACK     = 1'b0;
        #12;
        tests++;
        if (nDTACK !== 1'b1 || DATA_OE !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: dtack=%b oe=%b want 1 0",
                     nDTACK, DATA_OE);
        end
        tests++;
        if (BK_RD !== 1'b0 || BK_WR !== 1'b0 || TIMEOUT_FLAG !== 1'b0) begin
            fails++;
            $display("FAIL reset_req: rd=%b wr=%b to=%b want 0 0 0",
                     BK_RD, BK_WR, TIMEOUT_FLAG);
        end
        tests++;
        if (RDATA !== 16'h0 || BK_ADDR !== 23'h0 ||
            BK_WDATA !== 16'h0 || BK_BE !== 2'b00) begin
            fails++;
            $display("FAIL reset_data: rd=%h a=%h wd=%h be=%b want zeros",
                     RDATA, BK_ADDR, BK_WDATA, BK_BE);
        end
        @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        do_read(24'h100010, 16'hBEEF, "read");
    endtask

    task automatic test_write();
        @(negedge clk);
        M68K_ADDR  = 23'h080010;
        M68K_WDATA = 16'h0055;
        M68K_RW    = 1'b0;
        nAS        = 1'b0;
        @(negedge clk);
        tests++;
        if (BK_WR !== 1'b0) begin
            fails++;
            $display("FAIL write_no_ds: wr=%b want 0", BK_WR);
        end
        nLDS = 1'b0;
        @(negedge clk);
        tests++;
        if (BK_WR !== 1'b1 || BK_RD !== 1'b0 || BK_BE !== 2'b01 ||
            BK_WDATA !== 16'h0055) begin
            fails++;
            $display("FAIL write_req: wr=%b rd=%b be=%b wd=%h want 1 0 01 0055",
                     BK_WR, BK_RD, BK_BE, BK_WDATA);
        end
        @(negedge clk);
        tests++;
        if (BK_WR !== 1'b0) begin
            fails++;
            $display("FAIL write_single: wr=%b want 0", BK_WR);
        end
        BK_ACK = 1'b1;
        @(negedge clk);
        BK_ACK = 1'b0;
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b1) begin
            fails++;
            $display("FAIL write_early: dtack=%b want 1", nDTACK);
        end
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b0 || DATA_OE !== 1'b0 || RDATA !== last_rd) begin
            fails++;
            $display("FAIL write_ack: dtack=%b oe=%b rdata=%h want 0 0 %h",
                     nDTACK, DATA_OE, RDATA, last_rd);
        end
        bus_idle();
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b1) begin
            fails++;
            $display("FAIL write_release: dtack=%b want 1", nDTACK);
        end
    endtask

    task automatic test_miss();
        int bad;
        bad = 0;
        @(negedge clk);
        M68K_ADDR = 23'h100000;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (BK_RD !== 1'b0 || BK_WR !== 1'b0 || nDTACK !== 1'b1)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL miss: %0d bad cycles want 0", bad);
        end
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_abort();
        int bad;
        bad = 0;
        @(negedge clk);
        M68K_ADDR = 23'h080020;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b0;
        BK_RDATA  = 16'h1234;
        @(negedge clk);
        tests++;
        if (BK_RD !== 1'b1) begin
            fails++;
            $display("FAIL abort_req: rd=%b want 1", BK_RD);
        end
        @(negedge clk);
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            BK_ACK = (i == 2);
            if (nDTACK !== 1'b1 || DATA_OE !== 1'b0)
                bad++;
        end
        BK_ACK = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL abort_dtack: %0d low cycles want 0", bad);
        end
        tests++;
        if (RDATA !== last_rd) begin
            fails++;
            $display("FAIL abort_rdata: got %h want %h", RDATA, last_rd);
        end
        do_read(24'h100050, 16'hCAFE, "abort_recover");
    endtask

    task automatic test_wait_abort();
        int bad;
        bad = 0;
        @(negedge clk);
        M68K_ADDR = 23'h080030;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b0;
        BK_RDATA  = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        BK_ACK = 1'b1;
        @(negedge clk);
        BK_ACK = 1'b0;
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (nDTACK !== 1'b1)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL wait_abort: %0d low cycles want 0", bad);
        end
        last_rd = 16'h7777;
        tests++;
        if (RDATA !== last_rd) begin
            fails++;
            $display("FAIL wait_abort_rdata: got %h want %h", RDATA, last_rd);
        end
    endtask

    task automatic test_back_to_back();
        do_read(24'h100100, 16'hA5A5, "b2b_first");
        M68K_ADDR = 23'h080081;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b1;
        BK_RDATA  = 16'h5A5A;
        @(negedge clk);
        tests++;
        if (BK_RD !== 1'b1 || BK_ADDR !== 23'h080081 || BK_BE !== 2'b10) begin
            fails++;
            $display("FAIL b2b_start: rd=%b a=%h be=%b want 1 080081 10",
                     BK_RD, BK_ADDR, BK_BE);
        end
        @(negedge clk);
        BK_ACK = 1'b1;
        @(negedge clk);
        BK_ACK = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b0 || RDATA !== 16'h5A5A) begin
            fails++;
            $display("FAIL b2b_ack: dtack=%b rdata=%h want 0 5a5a",
                     nDTACK, RDATA);
        end
        bus_idle();
        @(negedge clk);
        last_rd = 16'h5A5A;
    endtask

    task automatic test_reset_in_ack();
        @(negedge clk);
        M68K_ADDR = 23'h080040;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b0;
        BK_RDATA  = 16'h4242;
        @(negedge clk);
        @(negedge clk);
        BK_ACK = 1'b1;
        @(negedge clk);
        BK_ACK = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b0 || DATA_OE !== 1'b1) begin
            fails++;
            $display("FAIL rst_ack_pre: dtack=%b oe=%b want 0 1",
                     nDTACK, DATA_OE);
        end
        #2 nRESET = 1'b0;
        #1;
        tests++;
        if (nDTACK !== 1'b1 || DATA_OE !== 1'b0) begin
            fails++;
            $display("FAIL rst_ack_async: dtack=%b oe=%b want 1 0",
                     nDTACK, DATA_OE);
        end
        tests++;
        if (RDATA !== 16'h0 || BK_ADDR !== 23'h0) begin
            fails++;
            $display("FAIL rst_ack_data: rdata=%h a=%h want 0 0",
                     RDATA, BK_ADDR);
        end
        bus_idle();
        @(negedge clk);
        nRESET = 1'b1;
        do_read(24'h100200, 16'h9C3E, "post_reset");
    endtask

    task automatic test_timeout();
`ifdef M68K_BUS_RESPONDER_TIMEOUT_EN
        int bad;
        bad = 0;
        @(negedge clk);
        M68K_ADDR = 23'h080300;
        M68K_RW   = 1'b1;
        nAS       = 1'b0;
        nUDS      = 1'b0;
        nLDS      = 1'b0;
        BK_RDATA  = 16'h1111;
        @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (nDTACK !== 1'b1)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL to_early: %0d low cycles want 0", bad);
        end
        @(negedge clk);
        tests++;
        if (nDTACK !== 1'b0 || RDATA !== 16'hFFFF || TIMEOUT_FLAG !== 1'b1) begin
            fails++;
            $display("FAIL to_ack: dtack=%b rdata=%h flag=%b want 0 ffff 1",
                     nDTACK, RDATA, TIMEOUT_FLAG);
        end
        BK_ACK = 1'b1;
        bus_idle();
        @(negedge clk);
        BK_ACK = 1'b0;
        tests++;
        if (nDTACK !== 1'b1 || RDATA !== 16'hFFFF || TIMEOUT_FLAG !== 1'b1) begin
            fails++;
            $display("FAIL to_late_ack: dtack=%b rdata=%h flag=%b want 1 ffff 1",
                     nDTACK, RDATA, TIMEOUT_FLAG);
        end
        do_read(24'h100310, 16'h0F0F, "to_after");
        tests++;
        if (TIMEOUT_FLAG !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky: flag=%b want 1", TIMEOUT_FLAG);
        end
        #2 nRESET = 1'b0;
        #1;
        tests++;
        if (TIMEOUT_FLAG !== 1'b0) begin
            fails++;
            $display("FAIL to_clear: flag=%b want 0", TIMEOUT_FLAG);
        end
        @(negedge clk);
        nRESET = 1'b1;
`else
        do_read(24'h100310, 16'h0F0F, "no_to");
        tests++;
        if (TIMEOUT_FLAG !== 1'b0) begin
            fails++;
            $display("FAIL to_tied: flag=%b want 0", TIMEOUT_FLAG);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_abort();
        test_wait_abort();
        test_back_to_back();
        test_reset_in_ack();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
